// File: rtl/ras_pkg.sv
// Shared definitions for the return-address-stack controller.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package ras_pkg;

  // Controller phases: memory scrub after reset, then normal operation.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ras_state_t;

  // Pointer width for a given entry count; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ras_ctrl_bram.sv
// Dual-port block RAM: port A write-only, port B registered read with sync output clear.
// Latency: port B data appears 1 cycle after b_en; read-first on address collision.
// Backpressure: none, both ports accept an access every cycle.
module ras_ctrl_bram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32,
  parameter int ADDR  = ras_pkg::ptr_w(DEPTH),
  parameter int INCR  = 0,
  parameter int OFS   = 0
) (
  input  logic             clk,
  input  logic             a_en,
  input  logic [ADDR-1:0]  a_addr,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_en,
  input  logic             b_rst,
  input  logic [ADDR-1:0]  b_addr,
  output logic [WIDTH-1:0] b_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Logical-to-physical address: optional stride (INCR+1) and base offset.
  function automatic logic [ADDR-1:0] phys(input logic [ADDR-1:0] a);
    return (a * ADDR'(INCR + 1)) + ADDR'(OFS);
  endfunction

  // Port A write.
  always_ff @(posedge clk) begin
    if (a_en) mem[phys(a_addr)] <= a_data;
  end

  // Port B read register; b_rst loads zero in place of a memory read.
  always_ff @(posedge clk) begin
    if (b_rst)     b_data <= '0;
    else if (b_en) b_data <= mem[phys(b_addr)];
  end

endmodule

// File: rtl/ras_ctrl.sv
// Circular return-address stack over a dual-port RAM; optional stats via RAS_CTRL_STATS_EN.
// Latency: pop result 1 cycle after the request; DEPTH-cycle memory scrub after reset.
// Backpressure: ready=0 during scrub and requests are dropped; full stack overwrites oldest entry.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32,
  parameter int ADDR  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             pop_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_underflow,
  output logic             ready,
  output logic [ADDR:0]    count,
  output logic             full,
  output logic             empty
`ifdef RAS_CTRL_STATS_EN
  ,
  output logic [15:0]      ovf_cnt,
  output logic [15:0]      udf_cnt
`endif
);

  localparam logic [ADDR:0]   FULL_CNT = (ADDR + 1)'(DEPTH);
  localparam logic [ADDR-1:0] LAST     = ADDR'(DEPTH - 1);

  ras_state_t       state, state_nxt;
  logic [ADDR-1:0]  init_addr;
  logic [ADDR-1:0]  tos;
  logic [ADDR-1:0]  tos_inc;
  logic [ADDR:0]    cnt;
  logic             pv_q, udf_q;

  logic             run;
  logic             do_flush, do_push, do_pop;
  logic             pop_hit, pop_udf, swap, push_adv, overflow;

  logic             a_en, b_en, b_rst;
  logic [ADDR-1:0]  a_addr, b_addr;
  logic [WIDTH-1:0] a_data, b_data;

  // Request decode: flush wins, and nothing is accepted outside RUN.
  assign run      = (state == RUN);
  assign do_flush = run & flush;
  assign do_push  = run & push & ~flush;
  assign do_pop   = run & pop & ~flush;
  assign pop_hit  = do_pop & (cnt != '0);
  assign pop_udf  = do_pop & (cnt == '0);
  assign swap     = do_push & pop_hit;        // replace top in place, pointer still
  assign push_adv = do_push & ~pop_hit;       // includes push alongside an underflowing pop
  assign overflow = push_adv & (cnt == FULL_CNT);
  assign tos_inc  = tos + ADDR'(1);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  // Scrub address walks every entry once; wraps back to 0 on entering RUN.
  always_ff @(posedge clk) begin
    if (!rst_n)             init_addr <= '0;
    else if (state == INIT) init_addr <= init_addr + ADDR'(1);
  end

  // FSM next state: leave INIT once the last entry has been zeroed.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_addr == LAST) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // FSM outputs: ready and the RAM port controls.
  always_comb begin
    ready  = 1'b0;
    a_en   = 1'b0;
    a_addr = tos_inc;
    a_data = push_data;
    b_en   = 1'b0;
    b_addr = tos;
    b_rst  = ~rst_n | pop_udf;
    case (state)
      INIT: begin
        a_en   = 1'b1;
        a_addr = init_addr;
        a_data = '0;
      end
      RUN: begin
        ready  = 1'b1;
        a_en   = do_push;
        a_addr = swap ? tos : tos_inc;
        b_en   = pop_hit;
      end
      default: ;
    endcase
  end

  // Top pointer and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tos <= LAST;
      cnt <= '0;
    end else if (do_flush) begin
      tos <= LAST;
      cnt <= '0;
    end else if (push_adv) begin
      tos <= tos_inc;
      if (!overflow) cnt <= cnt + (ADDR + 1)'(1);
    end else if (pop_hit && !do_push) begin
      tos <= tos - ADDR'(1);
      cnt <= cnt - (ADDR + 1)'(1);
    end
  end

  // Pop result flags, one cycle behind the accepted request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pv_q  <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pv_q  <= do_pop;
      udf_q <= pop_udf;
    end
  end

  assign pop_valid     = pv_q;
  assign pop_underflow = udf_q;
  assign pop_data      = pv_q ? b_data : '0;
  assign count         = cnt;
  assign full          = (cnt == FULL_CNT);
  assign empty         = (cnt == '0);

`ifdef RAS_CTRL_STATS_EN
  // Saturating event counters; flush deliberately leaves them alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
      udf_cnt <= '0;
    end else begin
      if (overflow && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
      if (pop_udf && udf_cnt != 16'hFFFF)  udf_cnt <= udf_cnt + 16'd1;
    end
  end
`endif

  ras_ctrl_bram #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .ADDR  (ADDR),
    .INCR  (0),
    .OFS   (0)
  ) u_bram (
    .clk    (clk),
    .a_en   (a_en),
    .a_addr (a_addr),
    .a_data (a_data),
    .b_en   (b_en),
    .b_rst  (b_rst),
    .b_addr (b_addr),
    .b_data (b_data)
  );

endmodule

// File: tb/tb_ras_ctrl.sv
// Testbench for ras_ctrl with DEPTH=4: directed scenarios plus random traffic against a queue model.
// Latency: results compared 1 time unit after each rising edge.
// Backpressure: model drops requests while the scrub phase is running.
module tb_ras_ctrl;
  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int ADDR  = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] push_data = '0;
  logic             pop_valid, pop_underflow, ready, full, empty;
  logic [WIDTH-1:0] pop_data;
  logic [ADDR:0]    count;
`ifdef RAS_CTRL_STATS_EN
  logic [15:0]      ovf_cnt, udf_cnt;
`endif

  ras_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR(ADDR)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .push          (push),
    .push_data     (push_data),
    .pop           (pop),
    .pop_valid     (pop_valid),
    .pop_data      (pop_data),
    .pop_underflow (pop_underflow),
    .ready         (ready),
    .count         (count),
    .full          (full),
    .empty         (empty)
`ifdef RAS_CTRL_STATS_EN
    ,
    .ovf_cnt       (ovf_cnt),
    .udf_cnt       (udf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the stack as a queue, newest at the back.
  logic [WIDTH-1:0] stk[$];
  int               init_left = DEPTH;
  int               ovf_m = 0;
  int               udf_m = 0;
  bit               exp_pv, exp_udf, exp_rdy;
  logic [WIDTH-1:0] exp_pd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ready", 32'(ready), 32'(exp_rdy));
    check("pop_valid", 32'(pop_valid), 32'(exp_pv));
    check("pop_underflow", 32'(pop_underflow), 32'(exp_udf));
    check("pop_data", pop_data, exp_pd);
    check("count", 32'(count), 32'(stk.size()));
    check("empty", 32'(empty), 32'(stk.size() == 0));
    check("full", 32'(full), 32'(stk.size() == DEPTH));
`ifdef RAS_CTRL_STATS_EN
    check("ovf_cnt", 32'(ovf_cnt), 32'(ovf_m > 16'hFFFF ? 16'hFFFF : ovf_m));
    check("udf_cnt", 32'(udf_cnt), 32'(udf_m > 16'hFFFF ? 16'hFFFF : udf_m));
`endif
  endtask

  // One clock: apply inputs, advance the model, then compare after the edge.
  task automatic step(input bit r, input bit f, input bit pu, input bit po, input logic [WIDTH-1:0] d);
    rst_n = r; flush = f; push = pu; pop = po; push_data = d;
    exp_pv = 1'b0; exp_udf = 1'b0; exp_pd = '0;
    if (!r) begin
      stk.delete();
      init_left = DEPTH;
      ovf_m = 0;
      udf_m = 0;
    end else if (init_left > 0) begin
      init_left--;
    end else if (f) begin
      stk.delete();
    end else begin
      if (po) begin
        exp_pv = 1'b1;
        if (stk.size() == 0) begin
          exp_udf = 1'b1;
          udf_m++;
        end else begin
          exp_pd = stk[$];
        end
      end
      if (pu) begin
        if (po && stk.size() > 0) begin
          stk[$] = d;
        end else begin
          if (stk.size() == DEPTH) begin
            void'(stk.pop_front());
            ovf_m++;
          end
          stk.push_back(d);
        end
      end else if (po && stk.size() > 0) begin
        void'(stk.pop_back());
      end
    end
    exp_rdy = r && (init_left == 0);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_push(input logic [WIDTH-1:0] d);
    step(1'b1, 1'b0, 1'b1, 1'b0, d);
  endtask

  task automatic do_pop();
    step(1'b1, 1'b0, 1'b0, 1'b1, '0);
  endtask

  initial begin
    // Reset and scrub: ready must rise only after DEPTH released cycles.
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h55);
    check("reset_empty", 32'(empty), 32'd1);
    for (int i = 0; i < DEPTH; i++) idle();
    check("init_ready_rise", 32'(ready), 32'd1);

    // LIFO order with 1-cycle latency.
    do_push(32'h100); do_push(32'h200); do_push(32'h300);
    do_pop();
    check("lifo_first", pop_data, 32'h300);
    do_pop(); do_pop(); idle();
    check("lifo_drained", 32'(empty), 32'd1);

    // Overflow wraps over the oldest entry, then underflow.
    for (int i = 1; i <= 5; i++) do_push(32'(i));
    check("ovf_full", 32'(full), 32'd1);
    for (int i = 0; i < 5; i++) do_pop();
    check("udf_flag", 32'(pop_underflow), 32'd1);
    check("udf_data", pop_data, 32'h0);
    idle();

    // Simultaneous push+pop replaces the top and returns the old value.
    do_push(32'hA);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'hB);
    check("swap_data", pop_data, 32'hA);
    do_pop();
    check("swap_next", pop_data, 32'hB);
    idle();

    // Push+pop on an empty stack: underflow plus a real push.
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'hC);
    do_pop();
    idle();

    // Flush beats a same-cycle push; a pop from the cycle before still lands.
    do_push(32'h10); do_push(32'h20);
    do_pop();
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h30);
    check("flush_count", 32'(count), 32'd0);
    do_pop();
    check("flush_udf", 32'(pop_underflow), 32'd1);
    idle();

    // Reset in the middle of scrub restarts it.
    do_push(32'h77);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    idle(); idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) idle();
    do_pop();
    check("rst_mid_init_data", pop_data, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 249) != 0),
           ($urandom_range(0, 19) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           $urandom);
    end
    for (int i = 0; i < DEPTH + 1; i++) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ras_ctrl.md
RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning number of stack entries (power of two, at least 4).
REQ-002 SHALL have parameter WIDTH, default 32, meaning return-address width in bits.
REQ-003 SHALL have parameter ADDR, default $clog2(DEPTH), meaning pointer width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have the following ports:
- flush, input, 1 bit: empty the stack.
- push, input, 1 bit: push request.
- push_data, input, WIDTH bits: address to push.
- pop, input, 1 bit: pop request.
- pop_valid, output, 1 bit: pop result valid.
- pop_data, output, WIDTH bits: popped address.
- pop_underflow, output, 1 bit: pop hit an empty stack.
- ready, output, 1 bit: requests accepted.
- count, output, ADDR+1 bits: occupancy.
- full, output, 1 bit: occupancy equals DEPTH.
- empty, output, 1 bit: occupancy equals 0.

Function
REQ-007 SHALL use a two-state FSM, INIT then RUN.
REQ-008 In INIT, SHALL write zero to addresses 0..DEPTH-1 through memory port A, one address per cycle, hold ready=0, and enter RUN after DEPTH cycles.
REQ-009 In RUN, SHALL hold ready=1, and SHALL ignore push, pop and flush while ready=0.
REQ-010 SHALL keep a top-of-stack pointer tos; all pointer arithmetic is modulo DEPTH.
REQ-011 For push only, SHALL:
- write push_data at tos+1 via port A;
- set tos to tos+1;
- set count to min(count+1, DEPTH).
REQ-012 For push while full, SHALL overwrite the oldest entry (circular), leave count at DEPTH and count one overflow.
REQ-013 For pop only with count>0, SHALL:
- read tos via port B;
- set tos to tos-1 and count to count-1;
- assert pop_valid the next cycle with pop_data equal to the stored value.
REQ-014 For pop only with count=0, SHALL leave tos and count unchanged and, the next cycle, assert pop_valid=1, pop_underflow=1 and pop_data=0, loading zero through the port B reset-data path.
REQ-015 For push and pop in the same cycle with count>0, SHALL:
- read tos on port B and write push_data at tos on port A;
- leave tos and count unchanged;
- return the pre-write value on pop_data the next cycle.
REQ-016 For push and pop in the same cycle with count=0, SHALL report the pop as an underflow (REQ-014) and perform the push as in REQ-011.
REQ-017 SHALL give flush priority over push and pop: set tos=DEPTH-1 and count=0 with no memory access; a pop_valid owed from the previous cycle is still delivered.
REQ-018 SHALL give pop a read latency of exactly 1 cycle.
REQ-019 SHALL hold pop_valid and pop_underflow for one cycle per accepted pop, and drive pop_data to 0 whenever pop_valid=0.
REQ-020 SHALL derive full, empty and count combinationally from the count register.

Reset
REQ-021 While rst_n=0, SHALL set:
- state=INIT with the init address at 0;
- tos=DEPTH-1, count=0;
- ready=0, pop_valid=0, pop_underflow=0, pop_data=0;
- empty=1, full=0.
REQ-022 SHALL treat reset asserted mid-INIT or mid-RUN as restarting the full INIT sequence; any in-flight pop result is discarded.

Configuration
REQ-023 With RAS_CTRL_STATS_EN defined, SHALL add two 16-bit outputs, ovf_cnt and udf_cnt. Each saturates at 16'hFFFF, increments once per overflowing push (REQ-012) or underflowing pop (REQ-014), is reset to 0 by rst_n, and is not cleared by flush.
REQ-024 Without RAS_CTRL_STATS_EN, SHALL omit those ports and counters entirely.

Structure
REQ-025 SHALL place the FSM state enum (INIT, RUN) and a pointer-width helper in shared package ras_pkg.
REQ-026 SHALL instantiate the team's dual-port bram module as its only sub-module, with INCR=0 and OFS=0.
REQ-027 SHALL wire bram port A for writes only and bram port B for reads only.

Verification
REQ-028 Use DEPTH=4 and WIDTH=32 in all scenarios.
REQ-029 Reset, then 4 cycles -> ready rises on cycle 5, count=0, empty=1.
REQ-030 Push 0x100, 0x200, 0x300, then 3 pops -> pop_data 0x300, 0x200, 0x100 at 1-cycle latency, then empty=1.
REQ-031 Push 0x1..0x5, then 5 pops -> 0x5, 0x4, 0x3, 0x2, then underflow with pop_data=0; with the macro defined, ovf_cnt=1 and udf_cnt=1.
REQ-032 Push 0xA, then push 0xB with pop in the same cycle -> pop_data=0xA, count=1, next pop returns 0xB.
REQ-033 Push 0x10, 0x20, then flush with push 0x30 in the same cycle -> count=0, next pop underflows.
REQ-034 rst_n low during INIT cycle 2 -> INIT restarts, ready rises 4 cycles after release, memory reads zero.
